valid_pattern_generator: RTL

TX-side valid-lane word generator feeding the mainband valid serializer. It produces the 32-bit valid-lane word that the far-end valid pattern detector samples.
- In training: emits a bounded VALTRAIN burst (8'b11110000 repeated x4 = 32'hF0F0F0F0) framed by zero lead-in and trail-out words.
- In mission mode: emits the valid framing pattern per functional data beat.
- Error injection corrupts pattern words so the detector's error-count and consecutive-match paths can be exercised.

---
 rtl/valid_pattern_generator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/valid_pattern_generator.sv
// TX valid-lane word generator: VALTRAIN bursts framed by zero lead/trail words,
// mission-mode framing per functional beat, and single-word error injection.
module valid_pattern_generator #(
  parameter int ITER_W      = 8,
  parameter int LEAD_WORDS  = 2,
  parameter int TRAIL_WORDS = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_valtrain,
  input  logic [ITER_W-1:0] i_iter_count,
  input  logic              i_abort,
  input  logic              i_func_valid,
  input  logic              i_ser_ready,
  input  logic              i_inject_err,
  output logic [31:0]       o_tvld_l,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_injected
);

  localparam logic [31:0]       PATTERN     = 32'hF0F0F0F0;
  localparam logic [31:0]       ERR_PATTERN = 32'hF0F0F0F1;
  localparam logic [3:0]        LEAD_LAST   = 4'(LEAD_WORDS - 1);
  localparam logic [3:0]        TRAIL_LAST  = 4'(TRAIL_WORDS - 1);
  localparam logic [ITER_W-1:0] ITER_ONE    = ITER_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_BURST, S_TRAIL} state_t;

  state_t              state_q, state_d;
  logic [31:0]         tvld_q, tvld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                inj_q, inj_d;
  logic [3:0]          lead_q, lead_d;
  logic [3:0]          trail_q, trail_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   remain_q, remain_d;
  logic                load_pat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      tvld_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      inj_q    <= 1'b0;
      lead_q   <= '0;
      trail_q  <= '0;
      iter_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      tvld_q   <= tvld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      inj_q    <= inj_d;
      lead_q   <= lead_d;
      trail_q  <= trail_d;
      iter_q   <= iter_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tvld_d   = tvld_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    inj_d    = inj_q | i_inject_err;
    lead_d   = lead_q;
    trail_d  = trail_q;
    iter_d   = iter_q;
    remain_d = remain_q;
    load_pat = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Start is accepted regardless of serializer readiness and beats func_valid.
        if (i_start_valtrain) begin
          iter_d = i_iter_count;
          tvld_d = '0;
          if (i_iter_count != '0) begin
            state_d = S_LEAD;
            busy_d  = 1'b1;
            lead_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end else if (i_ser_ready) begin
          tvld_d = i_func_valid ? PATTERN : '0;
        end
      end
      S_LEAD: begin
        if (i_ser_ready) begin
          if (lead_q == LEAD_LAST) begin
            state_d  = S_BURST;
            remain_d = iter_q;
            load_pat = 1'b1;
          end else begin
            lead_d = lead_q + 4'd1;
          end
        end
      end
      S_BURST: begin
        // remain counts words still to be consumed, including the one on the lane.
        if (i_ser_ready) begin
          remain_d = (remain_q != '0) ? remain_q - ITER_ONE : '0;
          if (remain_q <= ITER_ONE) begin
            state_d = S_TRAIL;
            tvld_d  = '0;
            trail_d = '0;
          end else begin
            load_pat = 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (i_ser_ready) begin
          if (trail_q == TRAIL_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tvld_d  = '0;
          end else begin
            trail_d = trail_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pending injection is spent on the next pattern word actually loaded.
    if (load_pat) begin
      if (inj_q) begin
        tvld_d = ERR_PATTERN;
        err_d  = 1'b1;
        inj_d  = i_inject_err;
      end else begin
        tvld_d = PATTERN;
      end
    end

    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tvld_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      inj_d   = 1'b0;
    end
  end

  assign o_tvld_l       = tvld_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err_injected = err_q;

endmodule
